// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: arbitration state, grant owner and
// memory write-enable codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CPU,
    LDR,
    LDR_LOCK
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_LDR
  } owner_t;

  localparam logic [1:0] MEMW_NONE = 2'b00;

  // Bit positions of each master inside the request/grant vectors
  localparam int REQ_CPU = 0;
  localparam int REQ_LDR = 1;

endpackage

// File: rtl/arb2_rr.sv
// Two-input round-robin arbiter (bit 0 = CPU, bit 1 = loader) with a bounded
// burst lock that lets the loader keep ownership for up to MAXBURST grants.
module arb2_rr
  import mem_arb_pkg::*;
#(
  parameter int MAXBURST = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      req,
  input  logic                            lock,
  output logic [1:0]                      gnt,
  output arb_state_t                      state,
  output logic [$clog2(MAXBURST+1)-1:0]   burst_cnt,
  output owner_t                          last
);

  localparam int CW = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0] MAXB = CW'(MAXBURST);

  arb_state_t     state_nxt;
  logic [CW-1:0]  cnt_nxt;
  owner_t         last_nxt;

  // Grant is purely combinational from the requests and last cycle's owner;
  // a lone requester always wins, ties honour the lock and then alternate.
  always_comb begin
    gnt       = 2'b00;
    state_nxt = IDLE;
    cnt_nxt   = '0;
    last_nxt  = last;

    if (!reset) begin
      case (req)
        2'b01: gnt[REQ_CPU] = 1'b1;
        2'b10: gnt[REQ_LDR] = 1'b1;
        2'b11: begin
          if (state == LDR_LOCK && burst_cnt < MAXB)
            gnt[REQ_LDR] = 1'b1;
          else if (last == OWN_LDR)
            gnt[REQ_CPU] = 1'b1;
          else
            gnt[REQ_LDR] = 1'b1;
        end
        default: gnt = 2'b00;
      endcase
    end

    if (gnt[REQ_CPU]) begin
      state_nxt = CPU;
      last_nxt  = OWN_CPU;
    end else if (gnt[REQ_LDR]) begin
      last_nxt = OWN_LDR;
      if (lock) begin
        state_nxt = LDR_LOCK;
        cnt_nxt   = (burst_cnt == MAXB) ? MAXB : burst_cnt + 1'b1;
      end else begin
        state_nxt = LDR;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last      <= OWN_LDR;
    end else begin
      state     <= state_nxt;
      burst_cnt <= cnt_nxt;
      last      <= last_nxt;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the MIPS core and the loader/debug
// master: muxes the granted access into memory and registers read data back.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N        = 32,
  parameter int MAXBURST = 8
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         cpu_req,
  input  logic [1:0]   cpu_we,
  input  logic [N-1:0] cpu_adr,
  input  logic [N-1:0] cpu_wdata,
  output logic         cpu_gnt,
  output logic         cpu_stall,
  output logic [N-1:0] cpu_rdata,
  output logic         cpu_rvalid,

  input  logic         ldr_req,
  input  logic         ldr_lock,
  input  logic [1:0]   ldr_we,
  input  logic [N-1:0] ldr_adr,
  input  logic [N-1:0] ldr_wdata,
  output logic         ldr_gnt,
  output logic [N-1:0] ldr_rdata,
  output logic         ldr_rvalid,

  output logic [N-1:0] mem_adr,
  output logic [N-1:0] mem_wdata,
  output logic [1:0]   mem_we,
  input  logic [N-1:0] mem_rdata
);

  localparam int CW = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0] MAXB = CW'(MAXBURST);

  logic [1:0]    gnt;
  arb_state_t    state;
  logic [CW-1:0] burst_cnt;
  owner_t        last;
  logic          cpu_rd;
  logic          ldr_rd;

  arb2_rr #(
    .MAXBURST (MAXBURST)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       ({ldr_req, cpu_req}),
    .lock      (ldr_lock),
    .gnt       (gnt),
    .state     (state),
    .burst_cnt (burst_cnt),
    .last      (last)
  );

  assign cpu_gnt   = gnt[REQ_CPU];
  assign ldr_gnt   = gnt[REQ_LDR];
  assign cpu_stall = cpu_req & ~gnt[REQ_CPU] & ~reset;

  assign cpu_rd = gnt[REQ_CPU] && (cpu_we == MEMW_NONE);
  assign ldr_rd = gnt[REQ_LDR] && (ldr_we == MEMW_NONE);

  // With no grant the CPU fields sit on the bus but the write is suppressed
  always_comb begin
    mem_adr   = cpu_adr;
    mem_wdata = cpu_wdata;
    mem_we    = MEMW_NONE;
    if (gnt[REQ_LDR]) begin
      mem_adr   = ldr_adr;
      mem_wdata = ldr_wdata;
      mem_we    = ldr_we;
    end else if (gnt[REQ_CPU]) begin
      mem_we = cpu_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      ldr_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_rd;
      ldr_rvalid <= ldr_rd;
      if (cpu_rd)
        cpu_rdata <= mem_rdata;
      if (ldr_rd)
        ldr_rdata <= mem_rdata;
    end
  end

  // Structural invariants between the arbiter's owner state and its counters
  a_one_hot:   assert property (@(posedge clk) disable iff (reset) !(&gnt));
  a_cnt_range: assert property (@(posedge clk) disable iff (reset) burst_cnt <= MAXB);
  a_lock_cnt:  assert property (@(posedge clk) disable iff (reset)
                 (state == LDR_LOCK) |-> (burst_cnt != '0));
  a_cpu_last:  assert property (@(posedge clk) disable iff (reset)
                 (state == CPU) |-> (last == OWN_CPU));
  a_ldr_last:  assert property (@(posedge clk) disable iff (reset)
                 (state == LDR || state == LDR_LOCK) |-> (last == OWN_LDR));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations plus a cycle-by-cycle reference model of the arbitration rules.
module tb_mem_arbiter;

  localparam int N        = 32;
  localparam int MAXBURST = 8;

  logic         clk;
  logic         reset;
  logic         cpu_req;
  logic [1:0]   cpu_we;
  logic [N-1:0] cpu_adr;
  logic [N-1:0] cpu_wdata;
  logic         cpu_gnt;
  logic         cpu_stall;
  logic [N-1:0] cpu_rdata;
  logic         cpu_rvalid;
  logic         ldr_req;
  logic         ldr_lock;
  logic [1:0]   ldr_we;
  logic [N-1:0] ldr_adr;
  logic [N-1:0] ldr_wdata;
  logic         ldr_gnt;
  logic [N-1:0] ldr_rdata;
  logic         ldr_rvalid;
  logic [N-1:0] mem_adr;
  logic [N-1:0] mem_wdata;
  logic [1:0]   mem_we;
  logic [N-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .N        (N),
    .MAXBURST (MAXBURST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_adr    (cpu_adr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .ldr_req    (ldr_req),
    .ldr_lock   (ldr_lock),
    .ldr_we     (ldr_we),
    .ldr_adr    (ldr_adr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .ldr_rdata  (ldr_rdata),
    .ldr_rvalid (ldr_rvalid),
    .mem_adr    (mem_adr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed 256-entry memory, preloaded on the first clock edge
  logic [N-1:0] mem [0:255];
  bit           memReady;

  assign mem_rdata = mem[mem_adr[9:2]];

  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= 32'hC0DE_0000 | i;
      mem[16]  <= 32'h1234_5678;
      mem[32]  <= 32'hAAAA_0001;
      mem[48]  <= 32'hBBBB_0002;
      memReady <= 1'b1;
    end else if (mem_we != 2'b00) begin
      mem[mem_adr[9:2]] <= mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic [1:0] cwe, input logic [N-1:0] cadr,
                               input logic [N-1:0] cwd, input logic lr, input logic ll,
                               input logic [1:0] lwe, input logic [N-1:0] ladr,
                               input logic [N-1:0] lwd);
    cpu_req   = cr;
    cpu_we    = cwe;
    cpu_adr   = cadr;
    cpu_wdata = cwd;
    ldr_req   = lr;
    ldr_lock  = ll;
    ldr_we    = lwe;
    ldr_adr   = ladr;
    ldr_wdata = lwd;
    #2;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 2'b00, '0, '0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who owned the bus, how long the loader has held a lock,
  // and which read returns are owed in the coming cycle.
  int           streak;
  bit           lastLdr;
  bit           expCpuRv;
  bit           expLdrRv;
  logic [N-1:0] expCpuRd;
  logic [N-1:0] expLdrRd;

  always @(negedge clk) begin : compare
    int           gsel;
    logic [1:0]   eWe;
    logic [N-1:0] eAdr;
    logic [N-1:0] eWd;
    if (reset) begin
      checkOutput("rst_cpu_gnt", cpu_gnt, 0);
      checkOutput("rst_ldr_gnt", ldr_gnt, 0);
      checkOutput("rst_stall", cpu_stall, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_cpu_rvalid", cpu_rvalid, 0);
      checkOutput("rst_ldr_rvalid", ldr_rvalid, 0);
      checkOutput("rst_cpu_rdata", cpu_rdata, 0);
      checkOutput("rst_ldr_rdata", ldr_rdata, 0);
      streak   <= 0;
      lastLdr  <= 1'b1;
      expCpuRv <= 1'b0;
      expLdrRv <= 1'b0;
      expCpuRd <= '0;
      expLdrRd <= '0;
    end else begin
      gsel = 0;
      if (cpu_req && !ldr_req)
        gsel = 1;
      else if (ldr_req && !cpu_req)
        gsel = 2;
      else if (cpu_req && ldr_req)
        gsel = (streak > 0 && streak < MAXBURST) ? 2 : (lastLdr ? 1 : 2);

      eWe  = (gsel == 1) ? cpu_we : ((gsel == 2) ? ldr_we : 2'b00);
      eAdr = (gsel == 2) ? ldr_adr : cpu_adr;
      eWd  = (gsel == 2) ? ldr_wdata : cpu_wdata;

      checkOutput("m_cpu_gnt", cpu_gnt, gsel == 1);
      checkOutput("m_ldr_gnt", ldr_gnt, gsel == 2);
      checkOutput("m_stall", cpu_stall, cpu_req && gsel != 1);
      checkOutput("m_mem_we", mem_we, eWe);
      checkOutput("m_mem_adr", mem_adr, eAdr);
      checkOutput("m_mem_wdata", mem_wdata, eWd);
      checkOutput("m_cpu_rvalid", cpu_rvalid, expCpuRv);
      checkOutput("m_ldr_rvalid", ldr_rvalid, expLdrRv);
      checkOutput("m_cpu_rdata", cpu_rdata, expCpuRd);
      checkOutput("m_ldr_rdata", ldr_rdata, expLdrRd);

      expCpuRv <= (gsel == 1 && cpu_we == 2'b00);
      expLdrRv <= (gsel == 2 && ldr_we == 2'b00);
      if (gsel == 1 && cpu_we == 2'b00)
        expCpuRd <= mem[cpu_adr[9:2]];
      if (gsel == 2 && ldr_we == 2'b00)
        expLdrRd <= mem[ldr_adr[9:2]];
      if (gsel == 2 && ldr_lock)
        streak <= (streak + 1 > MAXBURST) ? MAXBURST : streak + 1;
      else
        streak <= 0;
      if (gsel != 0)
        lastLdr <= (gsel == 2);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    reset = 1'b1;
    applyIdle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // CPU-only read of 0x40
    applyStimulus(1'b1, 2'b00, 32'h40, '0, 1'b0, 1'b0, 2'b00, '0, '0);
    checkOutput("t1_cpu_gnt", cpu_gnt, 1);
    checkOutput("t1_stall", cpu_stall, 0);
    nextCycle();
    applyIdle();
    checkOutput("t1_rvalid", cpu_rvalid, 1);
    checkOutput("t1_rdata", cpu_rdata, 32'h1234_5678);
    checkOutput("t1_stall_after", cpu_stall, 0);
    nextCycle();

    // Both read from reset: CPU, LDR, CPU, LDR
    reset = 1'b1;
    applyIdle();
    nextCycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'b00, 32'h80, '0, 1'b1, 1'b0, 2'b00, 32'hC0, '0);
      checkOutput("t2_cpu_gnt", cpu_gnt, (i % 2) == 0);
      checkOutput("t2_ldr_gnt", ldr_gnt, (i % 2) == 1);
      checkOutput("t2_stall", cpu_stall, (i % 2) == 1);
      checkOutput("t2_cpu_rvalid", cpu_rvalid, (i % 2) == 1);
      checkOutput("t2_ldr_rvalid", ldr_rvalid, (i >= 2) && ((i % 2) == 0));
      if (i % 2 == 1)
        checkOutput("t2_cpu_rdata", cpu_rdata, 32'hAAAA_0001);
      if (i == 2)
        checkOutput("t2_ldr_rdata", ldr_rdata, 32'hBBBB_0002);
      nextCycle();
    end
    applyIdle();
    checkOutput("t2_ldr_rvalid_end", ldr_rvalid, 1);
    checkOutput("t2_ldr_rdata_end", ldr_rdata, 32'hBBBB_0002);
    checkOutput("t2_cpu_rvalid_end", cpu_rvalid, 0);
    nextCycle();

    // Locked loader write burst against a waiting CPU
    applyStimulus(1'b1, 2'b00, 32'h100, '0, 1'b0, 1'b0, 2'b00, '0, '0);
    checkOutput("t3_cpu_first", cpu_gnt, 1);
    nextCycle();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 2'b00, 32'h100, '0, 1'b1, 1'b1, 2'b01,
                    32'h200 + 4 * k, 32'hD000_0000 + k);
      checkOutput("t3_ldr_gnt", ldr_gnt, 1);
      checkOutput("t3_stall", cpu_stall, 1);
      checkOutput("t3_ldr_rvalid", ldr_rvalid, 0);
      checkOutput("t3_cpu_rvalid", cpu_rvalid, k == 0);
      nextCycle();
    end
    applyStimulus(1'b1, 2'b00, 32'h100, '0, 1'b1, 1'b1, 2'b01, 32'h220, 32'hD000_0008);
    checkOutput("t3_cpu_after_burst", cpu_gnt, 1);
    checkOutput("t3_ldr_held_off", ldr_gnt, 0);
    nextCycle();
    applyIdle();
    checkOutput("t3_cpu_rdata", cpu_rdata, 32'hC0DE_0040);
    checkOutput("t3_ldr_rvalid_end", ldr_rvalid, 0);
    for (int k = 0; k < 8; k++)
      checkOutput("t3_mem_word", mem[8'h80 + k], 32'hD000_0000 + k);
    checkOutput("t3_no_extra_write", mem[8'h88], 32'hC0DE_0088);
    nextCycle();

    // Loader lock with the CPU idle; counter saturates, CPU still gets in
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 1'b1, 2'b00, 32'h40, '0);
      checkOutput("t4_ldr_gnt", ldr_gnt, 1);
      checkOutput("t4_burst_cnt", dut.burst_cnt, (k < 8) ? k : 8);
      nextCycle();
    end
    applyStimulus(1'b1, 2'b00, 32'h44, '0, 1'b1, 1'b1, 2'b00, 32'h40, '0);
    checkOutput("t4_cpu_gnt_c20", cpu_gnt, 1);
    checkOutput("t4_ldr_gnt_c20", ldr_gnt, 0);
    checkOutput("t4_cnt_sat", dut.burst_cnt, 8);
    nextCycle();

    // Write isolation: only the loader's write reaches memory
    applyStimulus(1'b1, 2'b01, 32'h340, 32'hBAD0_BAD0, 1'b1, 1'b0, 2'b11,
                  32'h300, 32'h600D_F00D);
    checkOutput("t5_ldr_gnt", ldr_gnt, 1);
    checkOutput("t5_cpu_gnt", cpu_gnt, 0);
    checkOutput("t5_mem_we", mem_we, 2'b11);
    checkOutput("t5_mem_adr", mem_adr, 32'h300);
    checkOutput("t5_mem_wdata", mem_wdata, 32'h600D_F00D);
    nextCycle();
    applyIdle();
    checkOutput("t5_cpu_loc", mem[8'hD0], 32'hC0DE_00D0);
    checkOutput("t5_ldr_loc", mem[8'hC0], 32'h600D_F00D);
    nextCycle();

    // Asynchronous reset in the middle of a locked burst
    applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 1'b1, 2'b00, 32'h40, '0);
    checkOutput("t6_ldr_gnt0", ldr_gnt, 1);
    nextCycle();
    applyStimulus(1'b1, 2'b00, 32'h44, '0, 1'b1, 1'b1, 2'b01, 32'h380, 32'hDEAD_0001);
    checkOutput("t6_pre_gnt", ldr_gnt, 1);
    checkOutput("t6_pre_rvalid", ldr_rvalid, 1);
    checkOutput("t6_pre_mem_we", mem_we, 2'b01);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_ldr_gnt", ldr_gnt, 0);
    checkOutput("t6_rst_cpu_gnt", cpu_gnt, 0);
    checkOutput("t6_rst_mem_we", mem_we, 0);
    checkOutput("t6_rst_rvalid", ldr_rvalid, 0);
    checkOutput("t6_rst_stall", cpu_stall, 0);
    nextCycle();
    reset = 1'b0;
    #2;
    checkOutput("t6_tie_cpu", cpu_gnt, 1);
    checkOutput("t6_tie_ldr", ldr_gnt, 0);
    checkOutput("t6_rdata_clr", ldr_rdata, 0);
    checkOutput("t6_no_write", mem[8'hE0], 32'hC0DE_00E0);
    nextCycle();
    applyIdle();
    nextCycle();
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the MIPS core data/instruction port and a loader/debug master (program loader, DMA). It sits between `mips`, the loader and `mem` in the top level, and multiplexes one address/write-data/write-enable set into the memory. It grants at most one requester per cycle, registers read data back to the winner, and stalls the core while the loader owns the memory. Tie arbitration is round-robin, plus a bounded burst lock for the loader.

## Interface
- `N`, 32: address/data width.
- `MAXBURST`, 8: maximum consecutive locked loader grants while the CPU is waiting (≥1).
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: CPU requests access this cycle.
- `cpu_we` in 2: CPU memwrite code; 2'b00 = read, any other value = write, passed through to memory unchanged.
- `cpu_adr`, `cpu_wdata` in N: CPU address / write data.
- `cpu_gnt` out 1: CPU access performed this cycle.
- `cpu_stall` out 1: `cpu_req & ~cpu_gnt`.
- `cpu_rdata` out N, `cpu_rvalid` out 1: registered read data and its valid flag.
- `ldr_req`, `ldr_lock` in 1: loader request; request to keep ownership for a burst.
- `ldr_we` in 2, `ldr_adr`, `ldr_wdata` in N: loader access fields.
- `ldr_gnt` out 1, `ldr_rdata` out N, `ldr_rvalid` out 1: as for the CPU.
- `mem_adr`, `mem_wdata` out N, `mem_we` out 2: to memory.
- `mem_rdata` in N: combinational read data from memory.

## Operation
- State register: `IDLE`, `CPU`, `LDR`, `LDR_LOCK` (the owner of the previous cycle), `burst_cnt` (0..MAXBURST, saturating), `last` (owner of the most recent grant, CPU/LDR).
- Grant decision is combinational from the requests and the registered state:
  - Only one requester active: grant it.
  - Both active, state `LDR_LOCK` and `burst_cnt < MAXBURST`: grant the loader.
  - Both active, any other case: grant the requester that is not `last`.
  - No requester active: no grant.
- Granted master's `adr/wdata/we` drive `mem_*`.
- No grant: `mem_we = 2'b00`, `mem_adr = cpu_adr`, `mem_wdata = cpu_wdata`.
- The write-enable of a non-granted master never reaches memory.
- Next state:
  - CPU grant → `CPU`; `burst_cnt` cleared.
  - Loader grant with `ldr_lock` high → `LDR_LOCK`; `burst_cnt` increments and saturates at MAXBURST.
  - Loader grant with `ldr_lock` low → `LDR`; `burst_cnt` cleared.
  - No grant → `IDLE`; `burst_cnt` cleared.
- `last` updates on every grant.
- Read return: on a granted read (`we == 00`), `mem_rdata` is captured into that master's `rdata`, and its `rvalid` pulses for one cycle.
- Writes do not produce `rvalid`. `rdata` holds its value until the next read by the same master.
- Reset values: state `IDLE`; `burst_cnt` 0; `last` = LDR, so the CPU wins the first tie; both `rdata` 0; both `rvalid` 0.
- While `reset` is high, both `gnt` outputs, `cpu_stall` and `mem_we` are forced to 0.
- Reset mid-burst or mid-read discards the pending return. Requesters must re-request.

## Timing
- Grant latency 0: `gnt` is in the same cycle as `req`. Memory writes at the rising edge ending the grant cycle.
- Read latency 1: grant in cycle t → `rvalid`/`rdata` valid in cycle t+1.
- Back-to-back grants to one master give `rvalid` on consecutive cycles.
- Requester holds `req`, `we`, `adr` and `wdata` stable until it sees `gnt`. Deasserting `req` before `gnt` cancels the request with no side effects.
- Worst-case CPU wait with the loader locked: MAXBURST cycles. Unlocked tie: 1 cycle.
- `ldr_lock` is ignored while `ldr_req` is low.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum (`IDLE`, `CPU`, `LDR`, `LDR_LOCK`).
  - `owner_t` enum (`OWN_CPU`, `OWN_LDR`).
  - `MEMW_NONE = 2'b00`.
- Sub-module `arb2_rr`: two-input round-robin grant with lock and burst counter. Outputs `gnt[1:0]` plus the state registers.
- Top `mem_arbiter` holds the `mem_*` muxing and the per-master read-return registers.

## Test plan
- CPU-only read, `cpu_adr = 0x40`, memory holds 0x1234_5678:
  - `cpu_gnt` = 1 in cycle t.
  - `cpu_rvalid` = 1 and `cpu_rdata` = 0x1234_5678 in t+1.
  - `cpu_stall` = 0 throughout.
- Both request from reset, both reads:
  - Grant order is CPU, LDR, CPU, LDR.
  - Each `rvalid` lands one cycle after its grant.
  - `cpu_stall` is high on the LDR cycles.
- Locked loader write burst, MAXBURST = 8, `ldr_lock` = 1, `ldr_we` = 01, CPU requesting throughout:
  - 8 consecutive `ldr_gnt`, then `cpu_gnt`.
  - Memory contains the 8 loader words.
  - No `rvalid` is produced.
- Loader lock held with the CPU idle for 20 cycles:
  - 20 loader grants; `burst_cnt` saturates at 8.
  - CPU raising `cpu_req` at cycle 20 is granted in cycle 20.
- Write isolation:
  - CPU asserts `cpu_we = 01` while the loader is granted.
  - `mem_we` equals `ldr_we`, and the CPU address location is unchanged.
- Async reset asserted mid-burst between clock edges:
  - `gnt`, `mem_we` and `rvalid` drop to 0 immediately.
  - After release, the first tie goes to the CPU.
